// File: rtl/rx_frame_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : rx_frame_buf_ctrl
//  Purpose  : Ping-pong frame buffer between the RMII MAC receiver and a
//             downstream consumer. Received bytes are written into one of two
//             byte banks. A bank is committed when the receiver signals a
//             good frame. Committed frames are streamed out in arrival order.
//             A frame that arrives while both banks hold unread frames is
//             dropped.
//  Optional : RXBUF_DROP_CNT_EN adds o_drop_cnt and a saturating DROP_W-bit
//             counter of dropped frames. When it is not defined, dropped
//             frames are discarded silently.
//  Ports    : i_clk, i_rst        clock, synchronous active-high reset
//             i_wren/i_wraddr/    receiver byte write stream
//             i_wrdata
//             i_data_ready        frame-good indication, edge detected
//             o_frm_avail/        committed frame ready to read, and its
//             o_frm_len           length in bytes
//             i_rd_start          consumer request to stream the frame
//             o_rd_valid/         read byte stream, one byte per cycle,
//             o_rd_data/          with no backpressure; o_rd_last marks
//             o_rd_last           the final byte
//             o_busy              readout in progress
//             o_drop_cnt          dropped-frame count (optional)
//  Revision : 1.0  initial release
// ============================================================================
module rx_frame_buf_ctrl #(
    parameter int ADDR_W  = 11,
    parameter int MAX_LEN = 139,
    parameter int DROP_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wren,
    input  logic [ADDR_W-1:0] i_wraddr,
    input  logic [7:0]        i_wrdata,
    input  logic              i_data_ready,
    output logic              o_frm_avail,
    output logic [ADDR_W:0]   o_frm_len,
    input  logic              i_rd_start,
    output logic              o_rd_valid,
    output logic [7:0]        o_rd_data,
    output logic              o_rd_last,
    output logic              o_busy
`ifdef RXBUF_DROP_CNT_EN
    ,
    output logic [DROP_W-1:0] o_drop_cnt
`endif
);

    localparam int              c_depth   = 2 ** (ADDR_W + 1);
    localparam logic [ADDR_W:0] c_max_len = (ADDR_W + 1)'(MAX_LEN);
    localparam logic [ADDR_W:0] c_one     = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_RUN  = 2'd1,
        RD_FREE = 2'd2
    } rd_state_t;

    // Elaboration guard: a zero-width drop counter is meaningless.
    if (DROP_W < 1) begin : g_drop_w_check
        $error("rx_frame_buf_ctrl: DROP_W must be at least 1");
    end

    // ------------------------------------------------------------------
    // Storage and state
    // ------------------------------------------------------------------
    logic [7:0]      r_mem [0:c_depth-1];
    logic [7:0]      r_ram_q;
    logic [1:0]      r_full;
    logic [ADDR_W:0] r_len [0:1];
    logic            r_wr_bank;
    logic            r_rd_bank;
    logic [ADDR_W:0] r_wr_len;
    logic            r_wren_d;
    logic            r_rdy_d;

    rd_state_t       r_state;
    logic [ADDR_W:0] r_rd_cnt;
    logic            r_rd_valid;
    logic            r_rd_last;
    logic            r_busy;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    logic            w_first_wr;
    logic            w_addr_ok;
    logic [ADDR_W:0] w_wr_ext;
    logic [ADDR_W:0] w_len_base;
    logic            w_ram_we;
    logic            w_rdy_rise;
    logic            w_commit;
    logic            w_free;
    logic [1:0]      w_full_set;
    logic [1:0]      w_full_clr;

    assign w_first_wr = i_wren & ~r_wren_d;
    assign w_addr_ok  = ({1'b0, i_wraddr} < c_max_len);
    assign w_wr_ext   = {1'b0, i_wraddr} + c_one;
    // A new frame starts from zero length before this cycle's byte is folded in.
    assign w_len_base = w_first_wr ? '0 : r_wr_len;
    // Bytes aimed at a bank still holding an unread frame are discarded.
    assign w_ram_we   = i_wren & w_addr_ok & ~r_full[r_wr_bank];

    assign w_rdy_rise = i_data_ready & ~r_rdy_d;
    assign w_commit   = w_rdy_rise & (r_wr_len != '0) & ~r_full[r_wr_bank];
    assign w_free     = (r_state == RD_FREE);

    // Commit and free always target different banks, so both apply together.
    assign w_full_set = w_commit ? (2'b01 << r_wr_bank) : 2'b00;
    assign w_full_clr = w_free   ? (2'b01 << r_rd_bank) : 2'b00;

    always_ff @(posedge i_clk) begin
        if (w_ram_we) begin
            r_mem[{r_wr_bank, i_wraddr}] <= i_wrdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wren_d  <= 1'b0;
            r_rdy_d   <= 1'b0;
            r_wr_len  <= '0;
            r_wr_bank <= 1'b0;
            r_full    <= 2'b00;
            r_len[0]  <= '0;
            r_len[1]  <= '0;
        end else begin
            r_wren_d <= i_wren;
            r_rdy_d  <= i_data_ready;
            r_full   <= (r_full | w_full_set) & ~w_full_clr;

            // Length tracks the incoming frame even when its bank is occupied,
            // so that a frame arriving with no free bank is seen as a drop
            // rather than as an empty frame.
            if (i_wren) begin
                if (w_addr_ok && (w_wr_ext > w_len_base)) begin
                    r_wr_len <= w_wr_ext;
                end else begin
                    r_wr_len <= w_len_base;
                end
            end

            if (w_commit) begin
                r_len[r_wr_bank] <= r_wr_len;
                r_wr_bank        <= ~r_wr_bank;
            end
        end
    end

    // ------------------------------------------------------------------
    // Drop counter
    // ------------------------------------------------------------------
`ifdef RXBUF_DROP_CNT_EN
    logic              w_drop;
    logic [DROP_W-1:0] r_drop_cnt;

    assign w_drop = w_rdy_rise & (r_wr_len != '0) & r_full[r_wr_bank];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

    assign o_drop_cnt = r_drop_cnt;
`else
    // Frames that find no free bank are discarded without being counted.
`endif

    // ------------------------------------------------------------------
    // Read side
    // ------------------------------------------------------------------
    logic            w_frm_avail;
    logic [ADDR_W:0] w_cur_len;
    logic            w_rd_en;

    assign w_cur_len   = r_len[r_rd_bank];
    assign w_frm_avail = (r_state == RD_IDLE) & r_full[r_rd_bank];
    // The counter is one bit wider than the bank address so that a frame
    // filling a whole bank still terminates.
    assign w_rd_en     = (r_state == RD_RUN) & (r_rd_cnt < w_cur_len);

    always_ff @(posedge i_clk) begin
        if (w_rd_en) begin
            r_ram_q <= r_mem[{r_rd_bank, r_rd_cnt[ADDR_W-1:0]}];
        end
    end

    // RD_RUN issues one read per cycle. It stays one extra cycle after the
    // last read while that byte is presented. RD_FREE then releases the bank.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= RD_IDLE;
            r_rd_bank  <= 1'b0;
            r_rd_cnt   <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                RD_IDLE: begin
                    r_rd_valid <= 1'b0;
                    r_rd_last  <= 1'b0;
                    if (i_rd_start && w_frm_avail) begin
                        r_state  <= RD_RUN;
                        r_rd_cnt <= '0;
                        r_busy   <= 1'b1;
                    end
                end
                RD_RUN: begin
                    if (w_rd_en) begin
                        r_rd_valid <= 1'b1;
                        r_rd_last  <= (r_rd_cnt == (w_cur_len - c_one));
                        r_rd_cnt   <= r_rd_cnt + c_one;
                    end else begin
                        r_rd_valid <= 1'b0;
                        r_rd_last  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_state    <= RD_FREE;
                    end
                end
                RD_FREE: begin
                    r_rd_bank <= ~r_rd_bank;
                    r_state   <= RD_IDLE;
                end
                default: begin
                    r_rd_valid <= 1'b0;
                    r_rd_last  <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= RD_IDLE;
                end
            endcase
        end
    end

    assign o_frm_avail = w_frm_avail;
    assign o_frm_len   = w_frm_avail ? w_cur_len : '0;
    assign o_rd_valid  = r_rd_valid;
    // The RAM output register has no reset, so it is masked outside valid bytes.
    assign o_rd_data   = r_rd_valid ? r_ram_q : 8'h00;
    assign o_rd_last   = r_rd_last;
    assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_rx_frame_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rx_frame_buf_ctrl
//  Purpose  : Self-checking bench for rx_frame_buf_ctrl. Expected bytes are
//             queued when a frame is committed and compared as the design
//             streams them out.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rx_frame_buf_ctrl;

    localparam int ADDR_W  = 11;
    localparam int MAX_LEN = 139;

    logic              i_clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              i_wren = 1'b0;
    logic [ADDR_W-1:0] i_wraddr = '0;
    logic [7:0]        i_wrdata = '0;
    logic              i_data_ready = 1'b0;
    logic              i_rd_start = 1'b0;
    logic              o_frm_avail;
    logic [ADDR_W:0]   o_frm_len;
    logic              o_rd_valid;
    logic [7:0]        o_rd_data;
    logic              o_rd_last;
    logic              o_busy;
`ifdef RXBUF_DROP_CNT_EN
    logic [7:0]        o_drop_cnt;
`endif

    always #5 i_clk = ~i_clk;

    rx_frame_buf_ctrl #(
        .ADDR_W  (ADDR_W),
        .MAX_LEN (MAX_LEN),
        .DROP_W  (8)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_wren       (i_wren),
        .i_wraddr     (i_wraddr),
        .i_wrdata     (i_wrdata),
        .i_data_ready (i_data_ready),
        .o_frm_avail  (o_frm_avail),
        .o_frm_len    (o_frm_len),
        .i_rd_start   (i_rd_start),
        .o_rd_valid   (o_rd_valid),
        .o_rd_data    (o_rd_data),
        .o_rd_last    (o_rd_last),
        .o_busy       (o_busy)
`ifdef RXBUF_DROP_CNT_EN
        ,
        .o_drop_cnt   (o_drop_cnt)
`endif
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_rx     = 0;
    logic [8:0] exp_q [$];
    logic [8:0] exp_e;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Scoreboard consumer: every valid byte must match the head of the queue.
    always @(negedge i_clk) begin
        if (o_rd_valid === 1'b1) begin
            n_rx++;
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 32'd1, 32'd0);
            end else begin
                exp_e = exp_q.pop_front();
                check("rd_data", {24'd0, o_rd_data}, {24'd0, exp_e[7:0]});
                check("rd_last", {31'd0, o_rd_last}, {31'd0, exp_e[8]});
            end
        end
    end

    // Queue the bytes a frame of n writes should read back as (clipped at MAX_LEN).
    task automatic push_exp(input int n, input bit incr, input logic [7:0] val);
        int         cnt;
        logic [7:0] d;
        cnt = (n < MAX_LEN) ? n : MAX_LEN;
        for (int i = 0; i < cnt; i++) begin
            d = incr ? 8'(i) : val;
            exp_q.push_back({(i == cnt - 1), d});
        end
    endtask

    task automatic wr_frame(input int n, input bit incr, input logic [7:0] val);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
            i_wren   = 1'b1;
            i_wraddr = ADDR_W'(i);
            i_wrdata = incr ? 8'(i) : val;
        end
        @(posedge i_clk); #1;
        i_wren = 1'b0;
    endtask

    task automatic commit(input int ncyc);
        @(posedge i_clk); #1;
        i_data_ready = 1'b1;
        for (int i = 1; i < ncyc; i++) begin
            @(posedge i_clk); #1;
        end
        @(posedge i_clk); #1;
        i_data_ready = 1'b0;
    endtask

    // Waits for an available frame, checks its length, and issues a one-cycle
    // start (cycle T). Returns just after the edge that begins cycle T+1.
    task automatic start_read(input int len);
        int k;
        k = 0;
        @(negedge i_clk);
        while (o_frm_avail !== 1'b1 && k < 500) begin
            @(negedge i_clk);
            k++;
        end
        check("frm_avail", {31'd0, o_frm_avail}, 32'd1);
        check("frm_len", {20'd0, o_frm_len}, len);
        @(posedge i_clk); #1;
        i_rd_start = 1'b1;
        @(posedge i_clk); #1;
        i_rd_start = 1'b0;
    endtask

    task automatic do_read(input int len, input bit exp_next_avail);
        int k;
        bit done;
        start_read(len);
        k    = 1;
        done = 1'b0;
        while (!done && k < len + 50) begin
            @(negedge i_clk);
            if (k == 1) begin
                check("busy_at_T+1", {31'd0, o_busy}, 32'd1);
                check("valid_at_T+1", {31'd0, o_rd_valid}, 32'd0);
            end
            if (k == 2) begin
                check("valid_at_T+2", {31'd0, o_rd_valid}, 32'd1);
            end
            if (o_busy !== 1'b1) begin
                check("busy_low_cycle", k, len + 2);
                done = 1'b1;
            end else begin
                k++;
            end
        end
        if (!done) begin
            check("read_timeout", 32'd0, 32'd1);
        end
        @(negedge i_clk);
        check("next_avail_T+3+len", {31'd0, o_frm_avail}, {31'd0, exp_next_avail});
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int k;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1 i_rst = 1'b0;
        @(negedge i_clk);
        check("rst_avail", {31'd0, o_frm_avail}, 32'd0);
        check("rst_len", {20'd0, o_frm_len}, 32'd0);
        check("rst_valid", {31'd0, o_rd_valid}, 32'd0);
        check("rst_data", {24'd0, o_rd_data}, 32'd0);
        check("rst_last", {31'd0, o_rd_last}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
`ifdef RXBUF_DROP_CNT_EN
        check("rst_drop", {24'd0, o_drop_cnt}, 32'd0);
`endif

        // Start request with nothing available is ignored
        @(posedge i_clk); #1 i_rd_start = 1'b1;
        @(posedge i_clk); #1 i_rd_start = 1'b0;
        @(negedge i_clk);
        check("idle_start_busy", {31'd0, o_busy}, 32'd0);
        @(negedge i_clk);
        check("idle_start_valid", {31'd0, o_rd_valid}, 32'd0);

        // 1: full-size frame, ready held two cycles
        wr_frame(139, 1'b1, 8'h00);
        commit(2);
        push_exp(139, 1'b1, 8'h00);
        do_read(139, 1'b0);

        // Writes at or beyond MAX_LEN are discarded
        wr_frame(145, 1'b1, 8'h00);
        commit(1);
        push_exp(145, 1'b1, 8'h00);
        do_read(139, 1'b0);

        // 2: ready held two cycles commits only once
        wr_frame(40, 1'b0, 8'h77);
        commit(2);
        push_exp(40, 1'b0, 8'h77);
        do_read(40, 1'b0);

        // 3: both banks full, third frame dropped
        wr_frame(60, 1'b0, 8'h11); commit(1); push_exp(60, 1'b0, 8'h11);
        wr_frame(60, 1'b0, 8'h22); commit(1); push_exp(60, 1'b0, 8'h22);
        wr_frame(60, 1'b0, 8'h33); commit(1);
        repeat (2) @(negedge i_clk);
`ifdef RXBUF_DROP_CNT_EN
        check("drop_cnt_after_C", {24'd0, o_drop_cnt}, 32'd1);
`endif
        do_read(60, 1'b1);
        do_read(60, 1'b0);

        // 4: aborted frame is overwritten by the next one
        wr_frame(100, 1'b1, 8'h00);
        repeat (3) @(negedge i_clk);
        check("abort_no_avail", {31'd0, o_frm_avail}, 32'd0);
        wr_frame(64, 1'b0, 8'h5A);
        commit(1);
        push_exp(64, 1'b0, 8'h5A);
        do_read(64, 1'b0);

        // 5: write the other bank while reading
        wr_frame(139, 1'b1, 8'h00);
        commit(1);
        push_exp(139, 1'b1, 8'h00);
        fork
            do_read(139, 1'b1);
            begin
                repeat (5) @(posedge i_clk);
                wr_frame(50, 1'b0, 8'hA7);
                commit(1);
                push_exp(50, 1'b0, 8'hA7);
            end
        join
        do_read(50, 1'b0);

        // 6: reset in the middle of a readout
        wr_frame(139, 1'b1, 8'h00);
        commit(1);
        push_exp(139, 1'b1, 8'h00);
        n_rx = 0;
        start_read(139);
        k = 0;
        while (n_rx < 20 && k < 200) begin
            @(negedge i_clk);
            k++;
        end
        check("mid_read_byte20", {31'd0, (n_rx >= 20)}, 32'd1);
        @(posedge i_clk); #1 i_rst = 1'b1;
        @(posedge i_clk); #1 i_rst = 1'b0;
        exp_q.delete();
        @(negedge i_clk);
        check("rst_mid_valid", {31'd0, o_rd_valid}, 32'd0);
        check("rst_mid_avail", {31'd0, o_frm_avail}, 32'd0);
        check("rst_mid_busy", {31'd0, o_busy}, 32'd0);
`ifdef RXBUF_DROP_CNT_EN
        check("rst_mid_drop", {24'd0, o_drop_cnt}, 32'd0);
`endif

        // Normal operation resumes after reset
        wr_frame(10, 1'b0, 8'hC3);
        commit(1);
        push_exp(10, 1'b0, 8'hC3);
        do_read(10, 1'b0);

        repeat (5) @(negedge i_clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
